// File: rtl/mitm_cmd_ctrl_pkg.sv
// mitm_ctrl_pkg: shared constants and state types for the MITM command
// controller. It holds the PC command opcodes, the response and tag bytes,
// and the two FSM state enums.
// Build option: define MITM_CTRL_TAG_EN to prefix each forwarded snoop
// byte with a tag byte (see mitm_tx_arb).
package mitm_ctrl_pkg;

  localparam logic [7:0] OP_EN   = 8'h65;
  localparam logic [7:0] OP_DIS  = 8'h64;
  localparam logic [7:0] OP_STAT = 8'h73;

  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  localparam logic [7:0] TAG_B1  = 8'hB1;
  localparam logic [7:0] TAG_B2  = 8'hB2;

  typedef enum logic [1:0] {C_IDLE, C_ARG, C_RESP} cmd_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WLOW, T_WHIGH} tx_state_t;
  typedef enum logic [1:0] {SRC_RESP, SRC_B1, SRC_B2} src_t;

endpackage

// File: rtl/mitm_cmd_ctrl_if.sv
// mitm_cmd_ctrl_if: groups the byte strobes coming from the three uart_rx
// instances (PC, b1, b2) with the PC uart_tx handshake.
//   slave  : the controller side (takes rx strobes and tx ready, drives tx start/data)
//   master : the surrounding fabric side
interface mitm_cmd_ctrl_if;
  logic       pc_rx_valid;
  logic [7:0] pc_rx_data;
  logic       b1_rx_valid;
  logic [7:0] b1_rx_data;
  logic       b2_rx_valid;
  logic [7:0] b2_rx_data;
  logic       pc_tx_rdy;
  logic       pc_tx_en;
  logic [7:0] pc_tx_data;

  modport slave (
    input  pc_rx_valid, pc_rx_data, b1_rx_valid, b1_rx_data,
    input  b2_rx_valid, b2_rx_data, pc_tx_rdy,
    output pc_tx_en, pc_tx_data
  );

  modport master (
    output pc_rx_valid, pc_rx_data, b1_rx_valid, b1_rx_data,
    output b2_rx_valid, b2_rx_data, pc_tx_rdy,
    input  pc_tx_en, pc_tx_data
  );
endinterface

// File: rtl/mitm_cmd_ctrl_tx_arb.sv
// mitm_tx_arb: PC-side TX scheduler. It holds one snoop byte per board,
// arbitrates the PC uart_tx between the pending command response and the
// two snoop registers, and issues one start pulse per frame.
// Ports:
//   clk, rst              clock, async active-low reset
//   fwd_en[1:0]           forward mask (bit0 b1, bit1 b2)
//   b1_valid/b1_data      snooped byte strobe from board 1
//   b2_valid/b2_data      snooped byte strobe from board 2
//   resp_valid/resp_data  pending command response
//   resp_take             1 when the response frame is started
//   pc_tx_rdy             PC uart_tx idle
//   pc_tx_en/pc_tx_data   start pulse and byte to the PC uart_tx
//   ovf[1:0]              sticky holding-register overflow
// Build option MITM_CTRL_TAG_EN: each snoop byte is preceded by its tag.
module mitm_tx_arb
  import mitm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] fwd_en,
  input  logic       b1_valid,
  input  logic [7:0] b1_data,
  input  logic       b2_valid,
  input  logic [7:0] b2_data,
  input  logic       resp_valid,
  input  logic [7:0] resp_data,
  output logic       resp_take,
  input  logic       pc_tx_rdy,
  output logic       pc_tx_en,
  output logic [7:0] pc_tx_data,
  output logic [1:0] ovf
);

  tx_state_t       state, state_nxt;
  src_t            src, src_nxt;
  logic [7:0]      data_nxt;
  logic            ptr_b2, ptr_nxt;
  // Set while the frame just granted is a tag; its data byte goes next.
  logic            tag_phase, tag_nxt;
  logic [1:0][7:0] h_data;
  logic [1:0]      h_full;
  logic [1:0]      in_valid;
  logic [1:0][7:0] in_data;
  logic [1:0]      free;
  logic [1:0]      accept;
  logic [1:0]      drop;

  assign in_valid = {b2_valid, b1_valid};
  assign in_data  = {b2_data, b1_data};

  // A strobe in the same cycle its register is freed still lands.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      accept[i] = in_valid[i] && fwd_en[i] && (!h_full[i] || free[i]);
      drop[i]   = in_valid[i] && fwd_en[i] && h_full[i] && !free[i];
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    data_nxt  = pc_tx_data;
    ptr_nxt   = ptr_b2;
    tag_nxt   = tag_phase;
    free      = 2'b00;
    resp_take = 1'b0;
    pc_tx_en  = 1'b0;
    case (state)
      T_IDLE: begin
        if (pc_tx_rdy) begin
          if (tag_phase) begin
            // Data byte follows its tag with no other grant in between.
            data_nxt  = (src == SRC_B2) ? h_data[1] : h_data[0];
            tag_nxt   = 1'b0;
            state_nxt = T_SEND;
          end else if (resp_valid) begin
            src_nxt   = SRC_RESP;
            data_nxt  = resp_data;
            state_nxt = T_SEND;
          end else if (h_full[0] && (!h_full[1] || !ptr_b2)) begin
            src_nxt   = SRC_B1;
            ptr_nxt   = 1'b1;
`ifdef MITM_CTRL_TAG_EN
            data_nxt  = TAG_B1;
            tag_nxt   = 1'b1;
`else
            data_nxt  = h_data[0];
`endif
            state_nxt = T_SEND;
          end else if (h_full[1]) begin
            src_nxt   = SRC_B2;
            ptr_nxt   = 1'b0;
`ifdef MITM_CTRL_TAG_EN
            data_nxt  = TAG_B2;
            tag_nxt   = 1'b1;
`else
            data_nxt  = h_data[1];
`endif
            state_nxt = T_SEND;
          end
        end
      end
      T_SEND: begin
        pc_tx_en = 1'b1;
        // The source is released only once its own byte goes out.
        if (!tag_phase) begin
          resp_take = (src == SRC_RESP);
          free[0]   = (src == SRC_B1);
          free[1]   = (src == SRC_B2);
        end
        state_nxt = T_WLOW;
      end
      T_WLOW:  if (!pc_tx_rdy) state_nxt = T_WHIGH;
      T_WHIGH: if (pc_tx_rdy)  state_nxt = T_IDLE;
      default: state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= T_IDLE;
      src        <= SRC_RESP;
      ptr_b2     <= 1'b0;
      tag_phase  <= 1'b0;
      pc_tx_data <= 8'h00;
      h_full     <= 2'b00;
      ovf        <= 2'b00;
    end else begin
      state      <= state_nxt;
      src        <= src_nxt;
      ptr_b2     <= ptr_nxt;
      tag_phase  <= tag_nxt;
      pc_tx_data <= data_nxt;
      for (int i = 0; i < 2; i++) begin
        if (accept[i])    h_full[i] <= 1'b1;
        else if (free[i]) h_full[i] <= 1'b0;
        if (drop[i])      ovf[i]    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) h_data[i] <= in_data[i];
    end
  end

endmodule

// File: rtl/mitm_cmd_ctrl.sv
// mitm_cmd_ctrl: command controller for the UART man-in-the-middle fabric.
// Parses PC commands ('e' arg, 'd' arg, 's') into the forward mask and
// hands responses to mitm_tx_arb, which shares the PC uart_tx with the
// bytes snooped from b1/b2.
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-low
//   bus      mitm_cmd_ctrl_if.slave: PC/b1/b2 rx strobes, PC tx handshake
//   fwd_en   forward mask, bit0 = b1, bit1 = b2
//   cmd_err  1-cycle pulse on NAK or argument timeout
//   ovf      sticky snoop overflow, bit0 = b1, bit1 = b2
// Build option MITM_CTRL_TAG_EN: tagged snoop forwarding (in mitm_tx_arb).
module mitm_cmd_ctrl
  import mitm_ctrl_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 32000000,
  parameter int BAUD_RATE    = 9600,
  parameter int TO_BITS      = 20
) (
  input  logic                clk,
  input  logic                rst,
  mitm_cmd_ctrl_if.slave      bus,
  output logic [1:0]          fwd_en,
  output logic                cmd_err,
  output logic [1:0]          ovf
);

  localparam int TIMEOUT_CYC = SYSTEM_CLOCK / BAUD_RATE * TO_BITS;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  cmd_state_t  state, state_nxt;
  logic        op_en, op_en_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [7:0]  resp, resp_nxt;
  logic [1:0]  fwd_nxt;
  logic        err_nxt;
  logic        resp_take;

  always_comb begin
    state_nxt = state;
    op_en_nxt = op_en;
    timer_nxt = timer;
    resp_nxt  = resp;
    fwd_nxt   = fwd_en;
    err_nxt   = 1'b0;
    case (state)
      C_IDLE: begin
        if (bus.pc_rx_valid) begin
          if (bus.pc_rx_data == OP_EN || bus.pc_rx_data == OP_DIS) begin
            state_nxt = C_ARG;
            op_en_nxt = (bus.pc_rx_data == OP_EN);
            timer_nxt = '0;
          end else if (bus.pc_rx_data == OP_STAT) begin
            state_nxt = C_RESP;
            resp_nxt  = {6'b0, fwd_en};
          end else begin
            state_nxt = C_RESP;
            resp_nxt  = NAK;
            err_nxt   = 1'b1;
          end
        end
      end
      C_ARG: begin
        if (bus.pc_rx_valid) begin
          state_nxt = C_RESP;
          if (bus.pc_rx_data[7:2] != 6'b0) begin
            resp_nxt = NAK;
            err_nxt  = 1'b1;
          end else begin
            fwd_nxt  = op_en ? (fwd_en | bus.pc_rx_data[1:0])
                             : (fwd_en & ~bus.pc_rx_data[1:0]);
            resp_nxt = ACK;
          end
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          // Abandoned command: no response byte is queued.
          state_nxt = C_IDLE;
          err_nxt   = 1'b1;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      C_RESP: begin
        // PC bytes arriving here are dropped on purpose.
        if (resp_take) state_nxt = C_IDLE;
      end
      default: state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= C_IDLE;
      op_en   <= 1'b0;
      timer   <= '0;
      resp    <= 8'h00;
      fwd_en  <= 2'b00;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_en   <= op_en_nxt;
      timer   <= timer_nxt;
      resp    <= resp_nxt;
      fwd_en  <= fwd_nxt;
      cmd_err <= err_nxt;
    end
  end

  mitm_tx_arb u_tx_arb (
    .clk        (clk),
    .rst        (rst),
    .fwd_en     (fwd_en),
    .b1_valid   (bus.b1_rx_valid),
    .b1_data    (bus.b1_rx_data),
    .b2_valid   (bus.b2_rx_valid),
    .b2_data    (bus.b2_rx_data),
    .resp_valid (state == C_RESP),
    .resp_data  (resp),
    .resp_take  (resp_take),
    .pc_tx_rdy  (bus.pc_tx_rdy),
    .pc_tx_en   (bus.pc_tx_en),
    .pc_tx_data (bus.pc_tx_data),
    .ovf        (ovf)
  );

endmodule

// File: tb/tb_mitm_cmd_ctrl.sv
// Directed bench for mitm_cmd_ctrl with a behavioural PC uart_tx model.
// Timeout is shortened to 100/10*2 = 20 cycles.
module tb_mitm_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] fwd_en;
  logic       cmd_err;
  logic [1:0] ovf;

  int tests = 0;
  int fails = 0;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int err_cnt;
  int frame_cnt;
  int cyc = 0;
  int last_pulse = -1;
  int min_gap = 1000;
  int e0;

  always #5 clk = ~clk;

  mitm_cmd_ctrl_if bus();

  mitm_cmd_ctrl #(
    .SYSTEM_CLOCK(100),
    .BAUD_RATE   (10),
    .TO_BITS     (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .fwd_en  (fwd_en),
    .cmd_err (cmd_err),
    .ovf     (ovf)
  );

  // PC uart_tx model: busy for 6 cycles after each start pulse.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pc_tx_rdy <= 1'b1;
      frame_cnt     <= 0;
      err_cnt       <= 0;
    end else begin
      if (bus.pc_tx_en) begin
        cap.push_back(bus.pc_tx_data);
        bus.pc_tx_rdy <= 1'b0;
        frame_cnt     <= 6;
      end else if (frame_cnt > 0) begin
        frame_cnt <= frame_cnt - 1;
        if (frame_cnt == 1) bus.pc_tx_rdy <= 1'b1;
      end
      if (cmd_err) err_cnt <= err_cnt + 1;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.pc_tx_en) begin
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pc_byte(input logic [7:0] b);
    @(negedge clk);
    bus.pc_rx_valid = 1'b1;
    bus.pc_rx_data  = b;
    @(negedge clk);
    bus.pc_rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n);
    int k;
    k = 0;
    while (cap.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (15) @(negedge clk);
    check({tag, "_count"}, cap.size(), n);
  endtask

  task automatic push_snoop(input logic [7:0] tag, input logic [7:0] b);
`ifdef MITM_CTRL_TAG_EN
    exp_q.push_back(tag);
`endif
    exp_q.push_back(b);
  endtask

  task automatic check_seq(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, (i < cap.size()) ? {24'h0, cap[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
    end
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.pc_rx_valid = 1'b0;
    bus.pc_rx_data  = 8'h00;
    bus.b1_rx_valid = 1'b0;
    bus.b1_rx_data  = 8'h00;
    bus.b2_rx_valid = 1'b0;
    bus.b2_rx_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fwd_en", fwd_en, 2'b00);
    check("rst_ovf", ovf, 2'b00);
    check("rst_cmd_err", cmd_err, 1'b0);
    check("rst_tx_en", bus.pc_tx_en, 1'b0);
    check("rst_tx_data", bus.pc_tx_data, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 'e',0x03 -> mask 11 the cycle after the arg strobe, ACK sent
    pc_byte(8'h65);
    @(negedge clk);
    bus.pc_rx_valid = 1'b1;
    bus.pc_rx_data  = 8'h03;
    check("t1_fwd_before", fwd_en, 2'b00);
    @(posedge clk);
    #1;
    check("t1_fwd_after", fwd_en, 2'b11);
    @(negedge clk);
    bus.pc_rx_valid = 1'b0;
    wait_tx("t1", 1);
    exp_q.push_back(8'h06);
    check_seq("t1_tx");

    // 2: 'd',0x01 then 's' -> mask 10, status 0x02
    pc_byte(8'h64);
    pc_byte(8'h01);
    wait_tx("t2a", 1);
    check("t2_fwd", fwd_en, 2'b10);
    pc_byte(8'h73);
    wait_tx("t2b", 2);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h02);
    check_seq("t2_tx");

    // 3: unknown opcode and bad argument both NAK
    e0 = err_cnt;
    pc_byte(8'h41);
    wait_tx("t3a", 1);
    check("t3_err_op", err_cnt, e0 + 1);
    pc_byte(8'h65);
    pc_byte(8'h04);
    wait_tx("t3b", 2);
    check("t3_err_arg", err_cnt, e0 + 2);
    check("t3_fwd", fwd_en, 2'b10);
    exp_q.push_back(8'h15);
    exp_q.push_back(8'h15);
    check_seq("t3_tx");

    // 4: argument timeout, then a normal command
    e0 = err_cnt;
    pc_byte(8'h65);
    repeat (10) @(negedge clk);
    check("t4_err_early", err_cnt, e0);
    repeat (15) @(negedge clk);
    check("t4_err_timeout", err_cnt, e0 + 1);
    check("t4_no_tx", cap.size(), 0);
    pc_byte(8'h65);
    pc_byte(8'h01);
    wait_tx("t4", 1);
    check("t4_fwd", fwd_en, 2'b11);
    exp_q.push_back(8'h06);
    check_seq("t4_tx");

    // 5: simultaneous snoop bytes, then with a pending ACK
    @(negedge clk);
    bus.b1_rx_valid = 1'b1; bus.b1_rx_data = 8'hAA;
    bus.b2_rx_valid = 1'b1; bus.b2_rx_data = 8'h55;
    @(negedge clk);
    bus.b1_rx_valid = 1'b0;
    bus.b2_rx_valid = 1'b0;
`ifdef MITM_CTRL_TAG_EN
    wait_tx("t5a", 4);
`else
    wait_tx("t5a", 2);
`endif
    push_snoop(8'hB1, 8'hAA);
    push_snoop(8'hB2, 8'h55);
    check_seq("t5a_tx");

    pc_byte(8'h65);
    @(negedge clk);
    bus.pc_rx_valid = 1'b1; bus.pc_rx_data = 8'h03;
    bus.b1_rx_valid = 1'b1; bus.b1_rx_data = 8'h11;
    bus.b2_rx_valid = 1'b1; bus.b2_rx_data = 8'h22;
    @(negedge clk);
    bus.pc_rx_valid = 1'b0;
    bus.b1_rx_valid = 1'b0;
    bus.b2_rx_valid = 1'b0;
`ifdef MITM_CTRL_TAG_EN
    wait_tx("t5b", 5);
`else
    wait_tx("t5b", 3);
`endif
    exp_q.push_back(8'h06);
    push_snoop(8'hB1, 8'h11);
    push_snoop(8'hB2, 8'h22);
    check_seq("t5b_tx");

    // Disabled board: strobe discarded
    pc_byte(8'h64);
    pc_byte(8'h02);
    wait_tx("t5c", 1);
    check("t5c_fwd", fwd_en, 2'b01);
    cap.delete();
    @(negedge clk);
    bus.b2_rx_valid = 1'b1; bus.b2_rx_data = 8'h99;
    @(negedge clk);
    bus.b2_rx_valid = 1'b0;
    wait_tx("t5c_discard", 0);

    // 6: two b1 bytes while TX busy -> second dropped, ovf[0] set
    check("t6_ovf_before", ovf, 2'b00);
    pc_byte(8'h73);
    for (int k = 0; k < 50 && bus.pc_tx_rdy; k++) @(negedge clk);
    check("t6_busy", bus.pc_tx_rdy, 1'b0);
    bus.b1_rx_valid = 1'b1; bus.b1_rx_data = 8'h5A;
    @(negedge clk);
    bus.b1_rx_data = 8'h77;
    @(negedge clk);
    bus.b1_rx_valid = 1'b0;
    check("t6_ovf_set", ovf, 2'b01);
`ifdef MITM_CTRL_TAG_EN
    wait_tx("t6", 3);
`else
    wait_tx("t6", 2);
`endif
    exp_q.push_back(8'h01);
    push_snoop(8'hB1, 8'h5A);
    check_seq("t6_tx");
    check("t6_ovf_sticky", ovf, 2'b01);

    check("min_pulse_gap_ge4", (min_gap >= 4), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
